// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, ALU codes,
// b-operand mux encodings, FSM states and the decoded control word.
package alu_ctrl_fsm_pkg;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_PASS    = 4'b0100;
  localparam logic [3:0] OP_RAND    = 4'b0101;
  localparam logic [3:0] OP_ROR     = 4'b0110;
  localparam logic [3:0] OP_SHL     = 4'b0111;
  localparam logic [3:0] OP_XOR     = 4'b1000;
  localparam logic [3:0] OP_LDI     = 4'b1001;
  localparam logic [3:0] OP_BZ      = 4'b1010;
  localparam logic [3:0] OP_BNZ     = 4'b1011;
  localparam logic [3:0] OP_LW      = 4'b1100;
  localparam logic [3:0] OP_SW      = 4'b1101;
  localparam logic [3:0] OP_ILLEGAL = 4'b1110;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;
  localparam logic [3:0] ALU_RAND = 4'b0101;
  localparam logic [3:0] ALU_ROR  = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;

  localparam logic [1:0] BSEL_REG = 2'b00;
  localparam logic [1:0] BSEL_IMM = 2'b01;
  localparam logic [1:0] BSEL_ACC = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] b_sel;
    logic       acc_we;
    logic       is_branch;
    logic       br_on_zero;
    logic       is_mem;
    logic       mem_we;
    logic       is_halt;
    logic       is_illegal;
    logic       is_addsub;
  } ctrl_t;

  function automatic logic [7:0] sext5(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Bus between the control sequencer and instruction memory / datapath.
interface alu_ctrl_fsm_if;
  logic [8:0] instr;
  logic       branch_flag;
  logic       alu_overflow;
  logic       mem_ready;
  logic [7:0] pc;
  logic [3:0] alu_control;
  logic [1:0] b_sel;
  logic [2:0] rf_raddr;
  logic       acc_we;
  logic       acc_src;
  logic       mem_req;
  logic       mem_we;
  logic       halted;
  logic       ovf_sticky;
  logic       illegal_op;

  modport master (
    input  instr, branch_flag, alu_overflow, mem_ready,
    output pc, alu_control, b_sel, rf_raddr, acc_we, acc_src,
           mem_req, mem_we, halted, ovf_sticky, illegal_op
  );

  modport slave (
    output instr, branch_flag, alu_overflow, mem_ready,
    input  pc, alu_control, b_sel, rf_raddr, acc_we, acc_src,
           mem_req, mem_we, halted, ovf_sticky, illegal_op
  );
endinterface

// File: rtl/alu_ctrl_fsm_instr_decode.sv
// Combinational IR -> control-word decoder; the FSM decides when each field applies.
module alu_ctrl_fsm_instr_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [8:0] ir_i,
  output ctrl_t      ctrl_o
);

  logic [3:0] op_s;
  assign op_s = ir_i[8:5];

  // Opcode to control-word table
  always_comb begin
    ctrl_o = '0;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_PASS,
      OP_RAND, OP_ROR, OP_SHL, OP_XOR: begin
        ctrl_o.alu_control = op_s;
        ctrl_o.b_sel       = BSEL_REG;
        ctrl_o.acc_we      = 1'b1;
        ctrl_o.is_addsub   = (op_s == OP_ADD) || (op_s == OP_SUB);
      end
      OP_LDI: begin
        ctrl_o.alu_control = ALU_PASS;
        ctrl_o.b_sel       = BSEL_IMM;
        ctrl_o.acc_we      = 1'b1;
      end
      OP_BZ, OP_BNZ: begin
        // Passing the accumulator makes the ALU zero flag mean "acc == 0"
        ctrl_o.alu_control = ALU_PASS;
        ctrl_o.b_sel       = BSEL_ACC;
        ctrl_o.is_branch   = 1'b1;
        ctrl_o.br_on_zero  = (op_s == OP_BZ);
      end
      OP_LW: begin
        ctrl_o.is_mem = 1'b1;
        ctrl_o.mem_we = 1'b0;
      end
      OP_SW: begin
        ctrl_o.is_mem = 1'b1;
        ctrl_o.mem_we = 1'b1;
      end
      OP_HALT: begin
        ctrl_o.is_halt = 1'b1;
      end
      OP_ILLEGAL: begin
        ctrl_o.is_illegal = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEM/HALT FSM owning PC, IR
// and the sticky overflow / illegal-opcode flags.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_ctrl_fsm_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic       ovf_q, ovf_d;
  logic       ill_q, ill_d;
  ctrl_t      ctrl_s;
  logic       br_taken_s;

  alu_ctrl_fsm_instr_decode u_decode (
    .ir_i   (ir_q),
    .ctrl_o (ctrl_s)
  );

  assign br_taken_s = ctrl_s.is_branch &
                      (ctrl_s.br_on_zero ? bus.branch_flag : ~bus.branch_flag);

  // State, PC, IR and sticky-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= 8'd0;
      ir_q    <= 9'd0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state, PC and flag update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = bus.instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ovf_d = ovf_q | (ctrl_s.is_addsub & bus.alu_overflow);
        ill_d = ill_q | ctrl_s.is_illegal;
        if (ctrl_s.is_mem) begin
          state_d = ST_MEM;
        end else if (ctrl_s.is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          pc_d    = br_taken_s ? (pc_q + sext5(ir_q[4:0])) : (pc_q + 8'd1);
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + 8'd1;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode; MEM outputs follow state_q so reset drops mem_req at once
  always_comb begin
    bus.pc          = pc_q;
    bus.rf_raddr    = ir_q[2:0];
    bus.halted      = (state_q == ST_HALT);
    bus.ovf_sticky  = ovf_q;
    bus.illegal_op  = ill_q;
    bus.alu_control = ALU_ADD;
    bus.b_sel       = BSEL_REG;
    bus.acc_we      = 1'b0;
    bus.acc_src     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    case (state_q)
      ST_EXEC: begin
        bus.alu_control = ctrl_s.alu_control;
        bus.b_sel       = ctrl_s.b_sel;
        bus.acc_we      = ctrl_s.acc_we;
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = ctrl_s.mem_we;
        bus.acc_we  = bus.mem_ready & ~ctrl_s.mem_we;
        bus.acc_src = bus.mem_ready & ~ctrl_s.mem_we;
      end
      default: begin
        bus.acc_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: decode table, hand-written corner
// sequences and random instructions against an instruction-level model.
module tb_alu_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_fsm_if bus();

  alu_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0] ins;
    logic       bf;
    logic       ov;
    logic [3:0] e_alu;
    logic [1:0] e_bsel;
    logic       e_we;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_pc;
  logic       m_ovf;
  logic       m_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected EXEC-cycle {alu_control, b_sel, acc_we} for an opcode
  function automatic logic [6:0] exp_dec(input logic [3:0] op);
    logic [3:0] a;
    logic [1:0] b;
    logic       w;
    a = 4'd0; b = 2'd0; w = 1'b0;
    if (op <= 4'd8) begin a = op; w = 1'b1; end
    else if (op == 4'd9) begin a = 4'd4; b = 2'd1; w = 1'b1; end
    else if (op == 4'd10 || op == 4'd11) begin a = 4'd4; b = 2'd2; end
    return {a, b, w};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr = 9'd0; bus.branch_flag = 1'b0; bus.alu_overflow = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'd0; m_ovf = 1'b0; m_ill = 1'b0;
    chk("rst_pc", bus.pc, 0);
    chk("rst_alu", bus.alu_control, 0);
    chk("rst_bsel", bus.b_sel, 0);
    chk("rst_accwe", bus.acc_we, 0);
    chk("rst_memreq", bus.mem_req, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_ovf", bus.ovf_sticky, 0);
    chk("rst_ill", bus.illegal_op, 0);
  endtask

  // Runs one instruction from a FETCH negedge to the next FETCH/HALT negedge
  task automatic run_instr(input logic [8:0] ins, input logic bf, input logic ov, input int dly,
                           input logic [3:0] e_alu, input logic [1:0] e_bsel, input logic e_we,
                           output int n_req);
    logic [3:0] op;
    int off;
    logic taken;
    op = ins[8:5];
    n_req = 0;
    bus.instr = ins;
    bus.mem_ready = 1'($urandom);
    bus.branch_flag = 1'($urandom);
    bus.alu_overflow = 1'($urandom);
    #1;
    chk("fetch_pc", bus.pc, m_pc);
    chk("fetch_ctl", {bus.alu_control, bus.acc_we, bus.mem_req}, 0);
    @(negedge clk);
    bus.instr = 9'($urandom);
    bus.branch_flag = bf;
    bus.alu_overflow = ov;
    bus.mem_ready = 1'($urandom);
    #1;
    chk("exec_alu", bus.alu_control, e_alu);
    chk("exec_bsel", bus.b_sel, e_bsel);
    chk("exec_accwe", bus.acc_we, e_we);
    chk("exec_memreq", bus.mem_req, 0);
    chk("exec_raddr", bus.rf_raddr, ins[2:0]);
    if ((op == 4'd0 || op == 4'd1) && ov) m_ovf = 1'b1;
    if (op == 4'd14) m_ill = 1'b1;
    if (op <= 4'd11 || op == 4'd14) begin
      off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
      taken = (op == 4'd10) ? bf : ((op == 4'd11) ? !bf : 1'b0);
      m_pc = 8'((int'(m_pc) + (taken ? off : 1)) & 255);
    end
    @(negedge clk);
    if (op == 4'd12 || op == 4'd13) begin
      for (int k = 0; k <= dly; k++) begin
        bus.mem_ready = (k == dly);
        bus.instr = 9'($urandom);
        #1;
        if (bus.mem_req) n_req++;
        chk("mem_req", bus.mem_req, 1);
        chk("mem_we", bus.mem_we, (op == 4'd13));
        chk("mem_accwe", bus.acc_we, (k == dly) && (op == 4'd12));
        chk("mem_accsrc", bus.acc_src, (k == dly) && (op == 4'd12));
        chk("mem_pc_hold", bus.pc, m_pc);
        @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      m_pc = m_pc + 8'd1;
    end
    #1;
    chk("post_pc", bus.pc, m_pc);
    chk("post_ovf", bus.ovf_sticky, m_ovf);
    chk("post_ill", bus.illegal_op, m_ill);
    chk("post_halted", bus.halted, (op == 4'd15));
  endtask

  task automatic run_m(input logic [8:0] ins, input logic bf, input logic ov, input int dly,
                       output int n_req);
    logic [6:0] e;
    e = exp_dec(ins[8:5]);
    run_instr(ins, bf, ov, dly, e[6:3], e[2:1], e[0], n_req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int nr;
    logic [7:0] pc_frozen;

    tbl[0] = '{9'b0000_00001, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1};
    tbl[1] = '{9'b0001_00010, 1'b1, 1'b0, 4'd1, 2'd0, 1'b1};
    tbl[2] = '{9'b0010_00011, 1'b0, 1'b1, 4'd2, 2'd0, 1'b1};
    tbl[3] = '{9'b0011_00100, 1'b1, 1'b1, 4'd3, 2'd0, 1'b1};
    tbl[4] = '{9'b0100_00101, 1'b1, 1'b0, 4'd4, 2'd0, 1'b1};
    tbl[5] = '{9'b0101_00110, 1'b0, 1'b0, 4'd5, 2'd0, 1'b1};
    tbl[6] = '{9'b0110_00111, 1'b1, 1'b1, 4'd6, 2'd0, 1'b1};
    tbl[7] = '{9'b0111_00000, 1'b0, 1'b1, 4'd7, 2'd0, 1'b1};
    tbl[8] = '{9'b1000_00001, 1'b1, 1'b0, 4'd8, 2'd0, 1'b1};
    tbl[9] = '{9'b1001_10101, 1'b1, 1'b1, 4'd4, 2'd1, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].ins, tbl[i].bf, tbl[i].ov, 0, tbl[i].e_alu, tbl[i].e_bsel, tbl[i].e_we, nr);
      if (i == 0) begin
        chk("add_pc1", bus.pc, 1);
        chk("add_ovf", bus.ovf_sticky, 1);
      end
    end
    chk("tbl_pc10", bus.pc, 10);

    // Branch corners around pc = 10
    run_m(9'b1010_11101, 1'b1, 1'b0, 0, nr);
    chk("bz_taken", bus.pc, 7);
    repeat (3) run_m(9'b1001_00000, 1'b0, 1'b0, 0, nr);
    run_m(9'b1010_11101, 1'b0, 1'b0, 0, nr);
    chk("bz_not_taken", bus.pc, 11);
    run_m(9'b1011_11101, 1'b0, 1'b0, 0, nr);
    chk("bnz_taken", bus.pc, 8);
    run_m(9'b1011_11101, 1'b1, 1'b0, 0, nr);
    chk("bnz_not_taken", bus.pc, 9);

    // Offset -16 from 5, then walk to 255 and wrap through the illegal opcode
    do_reset();
    run_m(9'b1010_00101, 1'b1, 1'b0, 0, nr);
    run_m(9'b1010_10000, 1'b1, 1'b0, 0, nr);
    chk("bz_minus16", bus.pc, 245);
    repeat (10) run_m(9'b1001_00001, 1'b0, 1'b0, 0, nr);
    chk("pc_255", bus.pc, 255);
    run_m(9'b1110_00000, 1'b0, 1'b1, 0, nr);
    chk("ill_wrap_pc", bus.pc, 0);
    chk("ill_flag", bus.illegal_op, 1);

    // LW with four wait cycles
    run_m(9'b1100_00010, 1'b0, 1'b0, 4, nr);
    chk("lw_req_cycles", nr, 5);
    chk("lw_pc", bus.pc, 1);

    // SW with reset asserted mid-MEM
    run_m(9'b0000_00001, 1'b0, 1'b1, 0, nr);
    bus.instr = 9'b1101_00011;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sw_memreq", bus.mem_req, 1);
    chk("sw_memwe", bus.mem_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_memreq", bus.mem_req, 0);
    chk("arst_accwe", bus.acc_we, 0);
    chk("arst_pc", bus.pc, 0);
    chk("arst_ovf", bus.ovf_sticky, 0);
    do_reset();

    // Random instruction stream (no HALT)
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_m({op, 5'($urandom)}, 1'($urandom), 1'($urandom), $urandom_range(0, 3), nr);
    end

    // HALT freezes everything
    run_m(9'b1111_00000, 1'b0, 1'b0, 0, nr);
    pc_frozen = m_pc;
    for (int i = 0; i < 12; i++) begin
      bus.instr = 9'($urandom);
      bus.mem_ready = 1'($urandom);
      bus.branch_flag = 1'($urandom);
      bus.alu_overflow = 1'($urandom);
      @(negedge clk);
      #1;
      chk("halt_pc", bus.pc, pc_frozen);
      chk("halt_flag", bus.halted, 1);
      chk("halt_en", {bus.acc_we, bus.mem_req, bus.alu_control}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
# alu_ctrl_fsm

Multi-cycle control sequencer that drives the 8-bit ALU's 4-bit operation code and consumes its `BranchFlag` and overflow outputs. It fetches 9-bit instructions and decodes them into ALU, register-file, accumulator and data-memory controls. It also resolves branches from the ALU zero flag and owns the 8-bit program counter. It sits between instruction memory and the external datapath (register file, accumulator, ALU, data memory).

## Interface
- No parameters; widths are fixed: 8-bit data/PC, 9-bit instruction, 4-bit ALU code.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `instr`  in  9  instruction at `pc`; combinational instruction memory, valid in FETCH
- `branch_flag`  in  1  ALU zero flag (`y == 0`)
- `alu_overflow`  in  1  ALU carry/borrow out
- `mem_ready`  in  1  data-memory completion strobe
- `pc`  out  8  program counter
- `alu_control`  out  4  ALU operation code
- `b_sel`  out  2  ALU b-operand mux: 00 `reg[rs]`, 01 zero-extended imm5, 10 accumulator
- `rf_raddr`  out  3  register-file read index (`instr[2:0]` of the latched instruction)
- `acc_we`  out  1  accumulator write enable
- `acc_src`  out  1  0 = ALU result, 1 = memory read data
- `mem_req`  out  1  data-memory request; address = `reg[rs]`, write data = accumulator
- `mem_we`  out  1  1 = store, 0 = load; valid while `mem_req` is high
- `halted`  out  1  high in HALT
- `ovf_sticky`  out  1  sticky overflow
- `illegal_op`  out  1  sticky illegal-opcode flag

## Operation
- IR is 9 bits: `[8:5]` opcode, `[4:0]` field (rs = `[2:0]`, imm5, or signed branch offset).
- ALU ops 0000–1000 (ADD, SUB, AND, OR, PASS, RAND, ROR, SHL, XOR):
  - `alu_control` = opcode, `b_sel` = 00.
  - Result is written to the accumulator; PC advances by 1.
- 1001 LDI: `alu_control` = 0100 (pass), `b_sel` = 01, `acc_we`.
- 1010 BZ / 1011 BNZ:
  - `alu_control` = 0100, `b_sel` = 10, so `branch_flag` reports accumulator == 0.
  - Taken: `pc <= pc + sext(imm5)`, mod 256. Not taken: `pc + 1`.
- 1100 LW: MEM state with `mem_we` = 0. On `mem_ready`: `acc_we` = 1, `acc_src` = 1.
- 1101 SW: MEM state with `mem_we` = 1; no accumulator write.
- 1111 HALT: enter HALT; `pc` frozen; only reset exits.
- 1110: executed as a NOP (`pc + 1`, no writes) and sets `illegal_op`.
- `ovf_sticky` is set when an ADD or SUB in EXEC sees `alu_overflow` = 1. It is cleared only by reset.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH → EXEC: always.
  - EXEC → MEM for LW/SW; → HALT for 1111; → FETCH otherwise.
  - MEM → FETCH on `mem_ready`.

## Timing
- Reset (async assert, sync release): state FETCH, `pc` = 0, all outputs 0 (`alu_control` = 0000, `b_sel` = 00).
- FETCH: IR latches `instr`. All write enables and `mem_req` are low; `alu_control` = 0000.
- EXEC (one cycle):
  - Decoded controls are combinational from IR.
  - `acc_we` is a 1-cycle pulse.
  - `branch_flag` and `alu_overflow` are sampled at the end of EXEC.
  - `pc` updates at the end of EXEC for ALU, LDI, branch and NOP.
- Latency: ALU/LDI/branch/NOP = 2 cycles; LW/SW = 3 cycles minimum, plus any `mem_ready` wait.
- Memory handshake:
  - `mem_req` and `mem_we` rise on MEM entry and stay stable until the cycle `mem_ready` is high.
  - `mem_ready` outside MEM is ignored.
  - On a `mem_ready` cycle: `pc <= pc + 1`, and for LW `acc_we` = 1 in that same cycle.
  - `mem_ready` may stay low indefinitely; the FSM waits.
- PC wrap: 255 + 1 = 0; offset −16 from `pc` = 5 gives 245.
- Reset mid-MEM: `mem_req` drops immediately (async); no accumulator write.
- In HALT: all enables low, `halted` = 1, `instr` ignored.

## Structure
- Shared package holds:
  - Opcode constants (ADD … HALT, ILLEGAL).
  - ALU code constants 0000–1000; the ALU also uses these.
  - `b_sel` encodings.
  - FSM state enum.
- One sub-module is natural: `instr_decode`, the combinational IR → control-word decoder. The top module keeps the FSM, PC, IR and sticky flags.

## Test plan
- Reset then ADD, rs = 1, with `alu_overflow` = 1 → `alu_control` = 0000, `acc_we` pulse in EXEC, `pc` 0→1 after 2 cycles, `ovf_sticky` = 1.
- BZ, offset −3 (`5'b11101`), at `pc` = 10, `branch_flag` = 1 → `pc` = 7. Same with `branch_flag` = 0 → `pc` = 11. BNZ → inverse results.
- LW with `mem_ready` low for 4 cycles → `mem_req` held high 5 cycles, `acc_we` with `acc_src` = 1 only in the ready cycle, `pc` +1.
- SW, then assert `rst_n` low mid-MEM → `mem_req` drops asynchronously, `pc` = 0, `ovf_sticky` cleared.
- Opcode 1110 at `pc` = 255 → `illegal_op` = 1, no writes, `pc` wraps to 0.
- HALT → `halted` = 1, `pc` frozen for 10+ cycles under random `instr` and `mem_ready`.
